halfword_ram_responder: RTL and testbench
=========================================

Name: halfword_ram_responder

Overview:
- Target-side model/responder for the 16-bit halfword RAM bus that the RAM controller drives.
- Accepts one halfword read or write per request and applies a fixed access latency. Signals completion with a one-cycle DoneReading/DoneWriting pulse.
- Sits between the controller and the on-chip halfword storage; also serves as the bus responder in system simulation.

Parameters:
- ADDR_W, 10, word-address bits used. Storage holds 2**(ADDR_W+1) halfwords.
- LATENCY, 2, cycles from request acceptance to Done pulse (legal range 1..15).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- Reset  input  1  synchronous, active-high reset.
- RamReadEnable  input  1  read request.
- RamWriteEnable  input  1  write request.
- ByteEnable  input  2  halfword lane: 01 = low half [15:0], 10 = high half [31:16]; 00/11 = no request.
- RamByteAddress  input  32  byte address, word-aligned. Bits [1:0] are ignored.
- RamByteData  input  16  write data.
- RamData  output  16  read data, registered.
- DoneReading  output  1  one-cycle pulse: read complete, RamData valid this cycle.
- DoneWriting  output  1  one-cycle pulse: write committed.
- Busy  output  1  high in BUSY and DONE states.
- ProtocolError  output  1  sticky error flag; cleared only by Reset.

Behaviour:
- Reset values: RamData=0, DoneReading=0, DoneWriting=0, Busy=0, ProtocolError=0, state=IDLE, counter=0. Memory contents are not cleared.
- Reset asserted mid-access: the access is dropped, no Done pulse is issued, and no write is committed.
- Request valid condition: (RamReadEnable | RamWriteEnable) && ByteEnable in {01,10}.
- Halfword index = {RamByteAddress[ADDR_W+1:2], ByteEnable==10}. Upper address bits wrap silently.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - On a valid request, latch op, index and RamByteData; counter := LATENCY-1.
  - Go to DONE if LATENCY==1, otherwise go to BUSY.
- BUSY:
  - Counter decrements each cycle; go to DONE when the counter reaches 0.
  - Each BUSY cycle checks that the enable for the latched op is still high. If it has dropped, abort: return to IDLE, no Done, no write.
  - Changes on address, data or lane during BUSY are ignored; the latched values are used.
- Entry to DONE (registered on the same edge):
  - Write: mem[index] := latched data; DoneWriting=1.
  - Read: RamData := mem[index]; DoneReading=1.
- DONE lasts exactly one cycle, then returns to IDLE.
- In the cycle after DONE, IDLE samples the request afresh. The controller has advanced ByteEnable on the Done edge, so the request now carries the next lane or none.
- Latency: request present in cycle 0 → Done high in cycle LATENCY. A two-halfword access therefore takes 2*(LATENCY+1) cycles, minus the final idle cycle.
- RamData holds its last read value until the next read completes. Writes never change RamData.
- Simultaneous RamReadEnable and RamWriteEnable in IDLE: write wins and ProtocolError := 1.
- ByteEnable==11 with any enable in IDLE: no access and ProtocolError := 1.
- ByteEnable==00 with an enable high is legal and ignored.
- Read of a halfword written in the immediately preceding DONE cycle returns the new data (no read-during-write hazard, because accesses are sequential).

Decomposition:
- Package ram_bus_pkg holds:
  - LANE_NONE = 2'b00, LANE_LO = 2'b01, LANE_HI = 2'b10.
  - Enum resp_state_t {IDLE, BUSY, DONE}.
  - Function halfword_index(addr, lane).
- One sub-module, halfword_mem_array: single-port synchronous RAM, depth 2**(ADDR_W+1) x 16.
  - Write enable and registered read output.
  - Read data is captured so it is valid in the DONE cycle.
  - The FSM/counter lives in the top module.

Test Plan:
1. Write then read back (LATENCY=2):
   - Write 0xBEEF at addr 0x10 lane 01 → DoneWriting pulses once in cycle 2.
   - Read addr 0x10 lane 01 → DoneReading in cycle 2 with RamData=0xBEEF.
2. Full 32-bit sequence driven like the controller:
   - Lane 01 data 0x5678, then lane 10 data 0x1234 at addr 0x20.
   - Read both lanes → RamData 0x5678, then 0x1234. Exactly two Done pulses per direction.
3. Abort:
   - Drop RamWriteEnable in cycle 1 of a write of 0xAAAA to addr 0x30.
   - Required: no DoneWriting; a later read of 0x30 returns the previous contents (0x0000 after preload).
4. Error:
   - RamReadEnable and RamWriteEnable both high, lane 01, data 0x1111, addr 0x40 → ProtocolError=1 and stays 1.
   - A read of 0x40 returns 0x1111. The flag clears only after Reset.
5. Reset mid-access:
   - Assert Reset in BUSY during a write of 0x7777 to addr 0x50 → no Done, all outputs 0.
   - A subsequent read returns the old value.
   - Repeat with LATENCY=1 and check Done arrives in cycle 1.
6. Address wrap (ADDR_W=10):
   - Write 0xC0DE at 0x1000 (word 1024, wraps to word 0) → a read of 0x0000 returns 0xC0DE.

Source files
------------

// File: rtl/ram_bus_pkg.sv
// Shared definitions for the 16-bit halfword RAM bus.
// Lane encodings, responder FSM states and index helper.
package ram_bus_pkg;

    localparam logic [1:0] LANE_NONE = 2'b00;
    localparam logic [1:0] LANE_LO   = 2'b01;
    localparam logic [1:0] LANE_HI   = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } resp_state_t;

    // Full-width index; callers truncate to their storage depth (wraps).
    function automatic logic [30:0] halfword_index(
        input logic [31:0] addr,
        input logic [1:0]  lane
    );
        return {addr[31:2], lane == LANE_HI};
    endfunction

endpackage

// File: rtl/halfword_mem_array.sv
// Single-port synchronous halfword RAM with registered read data.
// Read data register holds until the next read; it is cleared by reset.
module halfword_mem_array #(
    parameter int ADDR_W = 10
) (
    input  logic            clk,
    input  logic            Reset,
    input  logic            we_i,
    input  logic            re_i,
    input  logic [ADDR_W:0] addr_i,
    input  logic [15:0]     wdata_i,
    output logic [15:0]     rdata_o
);

    logic [15:0] mem_q [2**(ADDR_W+1)];
    logic [15:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/halfword_ram_responder.sv
// Target-side responder for the halfword RAM bus.
// Fixed-latency single access, one-cycle Done pulse, sticky protocol error.
module halfword_ram_responder
    import ram_bus_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        RamReadEnable,
    input  logic        RamWriteEnable,
    input  logic [1:0]  ByteEnable,
    input  logic [31:0] RamByteAddress,
    input  logic [15:0] RamByteData,
    output logic [15:0] RamData,
    output logic        DoneReading,
    output logic        DoneWriting,
    output logic        Busy,
    output logic        ProtocolError
);

    localparam int IW = ADDR_W + 1;

    resp_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [15:0] data_q, data_d;
    logic        done_rd_q, done_rd_d;
    logic        done_wr_q, done_wr_d;
    logic        err_q, err_d;
    logic        go_done;
    logic        mem_we, mem_re;
    logic        any_en, lane_ok;
    logic [IW-1:0] req_idx;

    assign any_en  = RamReadEnable | RamWriteEnable;
    assign lane_ok = (ByteEnable == LANE_LO) || (ByteEnable == LANE_HI);
    assign req_idx = IW'(halfword_index(RamByteAddress, ByteEnable));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        idx_d     = idx_q;
        data_d    = data_q;
        done_rd_d = 1'b0;
        done_wr_d = 1'b0;
        err_d     = err_q;
        go_done   = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_en && lane_ok) begin
                    wr_d   = RamWriteEnable;
                    idx_d  = req_idx;
                    data_d = RamByteData;
                    cnt_d  = 4'(LATENCY - 1);
                    err_d  = err_q | (RamReadEnable & RamWriteEnable);
                    if (LATENCY == 1) begin
                        go_done = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end else if (any_en && ByteEnable == 2'b11) begin
                    err_d = 1'b1;
                end
            end
            BUSY: begin
                // Abort when the controller withdraws the latched op.
                if (wr_q ? !RamWriteEnable : !RamReadEnable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == 4'd1) begin
                    cnt_d   = '0;
                    go_done = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (go_done) begin
            state_d   = DONE;
            mem_we    = wr_d;
            mem_re    = !wr_d;
            done_wr_d = wr_d;
            done_rd_d = !wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            idx_q     <= '0;
            data_q    <= '0;
            done_rd_q <= 1'b0;
            done_wr_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            done_rd_q <= done_rd_d;
            done_wr_q <= done_wr_d;
            err_q     <= err_d;
        end
    end

    halfword_mem_array #(
        .ADDR_W(ADDR_W)
    ) u_mem (
        .clk    (clk),
        .Reset  (Reset),
        .we_i   (mem_we & ~Reset),
        .re_i   (mem_re & ~Reset),
        .addr_i (idx_d),
        .wdata_i(data_d),
        .rdata_o(RamData)
    );

    assign DoneReading   = done_rd_q;
    assign DoneWriting   = done_wr_q;
    assign Busy          = (state_q != IDLE);
    assign ProtocolError = err_q;

endmodule

// File: tb/tb_halfword_ram_responder.sv
// Directed bench for halfword_ram_responder with a read-data scoreboard.
// Instance 0 uses LATENCY=2, instance 1 uses LATENCY=1.
module tb_halfword_ram_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, re0, we0, rst1, re1, we1;
    logic [1:0]  be0, be1;
    logic [31:0] ad0, ad1;
    logic [15:0] wd0, wd1, rd0, rd1;
    logic        dr0, dw0, bs0, pe0, dr1, dw1, bs1, pe1;

    halfword_ram_responder #(.ADDR_W(10), .LATENCY(2)) u0 (
        .clk(clk), .Reset(rst0), .RamReadEnable(re0), .RamWriteEnable(we0),
        .ByteEnable(be0), .RamByteAddress(ad0), .RamByteData(wd0),
        .RamData(rd0), .DoneReading(dr0), .DoneWriting(dw0),
        .Busy(bs0), .ProtocolError(pe0)
    );

    halfword_ram_responder #(.ADDR_W(10), .LATENCY(1)) u1 (
        .clk(clk), .Reset(rst1), .RamReadEnable(re1), .RamWriteEnable(we1),
        .ByteEnable(be1), .RamByteAddress(ad1), .RamByteData(wd1),
        .RamData(rd1), .DoneReading(dr1), .DoneWriting(dw1),
        .Busy(bs1), .ProtocolError(pe1)
    );

    typedef struct {
        bit          wr;
        logic [15:0] d;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] model [int];
    int          tests = 0;
    int          fails = 0;
    int          nw0 = 0, nr0 = 0;

    always @(negedge clk) begin
        if (dw0) nw0++;
        if (dr0) nr0++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int key(input int u, input logic [31:0] a,
                               input logic [1:0] l);
        logic [10:0] i;
        i = {a[11:2], l == 2'b10};
        return u * 4096 + int'(i);
    endfunction

    function automatic logic [19:0] outs(input int u);
        if (u == 0) return {rd0, dr0, dw0, bs0, pe0};
        return {rd1, dr1, dw1, bs1, pe1};
    endfunction

    task automatic drive(input int u, input logic re, input logic we,
                         input logic [31:0] a, input logic [1:0] l,
                         input logic [15:0] d);
        if (u == 0) begin
            re0 = re; we0 = we; ad0 = a; be0 = l; wd0 = d;
        end else begin
            re1 = re; we1 = we; ad1 = a; be1 = l; wd1 = d;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int u);
        if (u == 0) rst0 = 1'b1; else rst1 = 1'b1;
        drive(u, 0, 0, 0, 2'b00, 0);
        step();
        step();
        check("reset_outs", 32'(outs(u)), 32'h0);
        if (u == 0) rst0 = 1'b0; else rst1 = 1'b0;
    endtask

    // One complete access, controller-style; returns after an idle cycle.
    task automatic req(input int u, input logic re, input logic we,
                       input logic [31:0] a, input logic [1:0] l,
                       input logic [15:0] d, input int lat, input string tag);
        int   k;
        bit   got;
        exp_t e;
        logic [19:0] o;
        drive(u, re, we, a, l, d);
        if (we) begin
            model[key(u, a, l)] = d;
            sb.push_back('{1'b1, d});
        end else begin
            sb.push_back('{1'b0, model.exists(key(u, a, l)) ?
                                 model[key(u, a, l)] : 16'h0});
        end
        k = 0;
        got = 0;
        while (k < 20 && !got) begin
            step();
            k++;
            o = outs(u);
            got = o[3] | o[2];
        end
        check({tag, "_latency"}, k, lat);
        if (got && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_kind"}, {31'h0, o[2]}, {31'h0, e.wr});
            check({tag, "_busy"}, {31'h0, o[1]}, 32'h1);
            if (!e.wr) check({tag, "_data"}, 32'(o[19:4]), 32'(e.d));
        end
        drive(u, 0, 0, a, 2'b00, d);
        step();
        o = outs(u);
        check({tag, "_pulse_end"}, 32'(o[3:1]), 32'h0);
    endtask

    initial begin
        int n;
        rst0 = 0; rst1 = 0;
        drive(0, 0, 0, 0, 2'b00, 0);
        drive(1, 0, 0, 0, 2'b00, 0);
        do_reset(0);
        do_reset(1);

        req(0, 0, 1, 32'h30, 2'b01, 16'h0000, 2, "pre30");
        req(0, 0, 1, 32'h50, 2'b01, 16'h0000, 2, "pre50");
        req(0, 0, 1, 32'h00, 2'b01, 16'h0000, 2, "pre00");

        n = nw0;
        req(0, 0, 1, 32'h10, 2'b01, 16'hBEEF, 2, "wr10");
        check("wr10_pulses", nw0 - n, 1);
        req(0, 1, 0, 32'h10, 2'b01, 16'h0000, 2, "rd10");

        n = nw0;
        req(0, 0, 1, 32'h20, 2'b01, 16'h5678, 2, "wr20lo");
        req(0, 0, 1, 32'h20, 2'b10, 16'h1234, 2, "wr20hi");
        check("wr20_pulses", nw0 - n, 2);
        check("rdata_hold", 32'(rd0), 32'hBEEF);
        n = nr0;
        req(0, 1, 0, 32'h20, 2'b01, 16'h0000, 2, "rd20lo");
        req(0, 1, 0, 32'h20, 2'b10, 16'h0000, 2, "rd20hi");
        check("rd20_pulses", nr0 - n, 2);

        n = nw0;
        drive(0, 0, 1, 32'h30, 2'b01, 16'hAAAA);
        step();
        drive(0, 0, 0, 32'h30, 2'b01, 16'hAAAA);
        repeat (4) step();
        check("abort_no_done", nw0 - n, 0);
        req(0, 1, 0, 32'h30, 2'b01, 16'h0000, 2, "rd30");

        check("err_clear", 32'(pe0), 32'h0);
        req(0, 1, 1, 32'h40, 2'b01, 16'h1111, 2, "rw40");
        check("err_set", 32'(pe0), 32'h1);
        req(0, 1, 0, 32'h40, 2'b01, 16'h0000, 2, "rd40");
        check("err_sticky", 32'(pe0), 32'h1);
        do_reset(0);

        n = nw0 + nr0;
        drive(0, 1, 0, 32'h40, 2'b00, 16'h0);
        step();
        check("lane00_busy", 32'(bs0), 32'h0);
        check("lane00_err", 32'(pe0), 32'h0);
        drive(0, 1, 0, 32'h40, 2'b11, 16'h0);
        step();
        drive(0, 0, 0, 32'h40, 2'b00, 16'h0);
        repeat (3) step();
        check("lane11_err", 32'(pe0), 32'h1);
        check("lane11_no_done", nw0 + nr0 - n, 0);
        do_reset(0);

        req(0, 1, 0, 32'h10, 2'b01, 16'h0000, 2, "rd10b");
        n = nw0;
        drive(0, 0, 1, 32'h50, 2'b01, 16'h7777);
        step();
        check("rst_mid_busy", 32'(bs0), 32'h1);
        rst0 = 1'b1;
        drive(0, 0, 0, 32'h50, 2'b00, 16'h7777);
        step();
        check("rst_mid_outs", 32'(outs(0)), 32'h0);
        rst0 = 1'b0;
        repeat (3) step();
        check("rst_mid_no_done", nw0 - n, 0);
        model[key(0, 32'h50, 2'b01)] = 16'h0000;
        req(0, 1, 0, 32'h50, 2'b01, 16'h0000, 2, "rd50");

        req(1, 0, 1, 32'h08, 2'b10, 16'h4321, 1, "l1_wr");
        req(1, 1, 0, 32'h08, 2'b10, 16'h0000, 1, "l1_rd");

        req(0, 0, 1, 32'h1000, 2'b01, 16'hC0DE, 2, "wr_wrap");
        req(0, 1, 0, 32'h0000, 2'b01, 16'h0000, 2, "rd_wrap");

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
